// File: rtl/rr_trace_pkg.sv
// Shared constants and types for the replay-side trace splitter.
package rr_trace_pkg;

  // Every record packet starts and ends on a frame of this many bits.
  localparam int unsigned PACKET_ALIGNMENT = 32;
  // Low bits of each packet that hold its total width in bits.
  localparam int unsigned LEN_BITS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StError
  } rr_split_state_t;

  // Round a bit count up to a whole number of frames (result still in bits).
  function automatic logic [31:0] get_force_aligned_frame(input logic [31:0] bits);
    return ((bits + 32'(PACKET_ALIGNMENT) - 32'd1) / 32'(PACKET_ALIGNMENT))
           * 32'(PACKET_ALIGNMENT);
  endfunction

endpackage

// File: rtl/rr_aligned_shifter.sv
// Frame-granular right shift of a buffer, followed by an optional overwrite of
// INS_W bits starting at a frame offset. Used for the consume/append path.
module rr_aligned_shifter #(
  parameter int unsigned BUF_W = 3072,
  parameter int unsigned INS_W = 512,
  parameter int unsigned FRAME = 32,
  localparam int unsigned NF = BUF_W / FRAME,
  localparam int unsigned FW = $clog2(NF + 1)
) (
  input  logic [BUF_W-1:0] buf_i,
  input  logic [FW-1:0]    shift_frames_i,
  input  logic             ins_en_i,
  input  logic [FW-1:0]    ins_frame_i,
  input  logic [INS_W-1:0] ins_data_i,
  output logic [BUF_W-1:0] buf_o
);

  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] ins_data;
  logic [BUF_W-1:0] ins_mask;

  // Shift out consumed frames, then overwrite the append window (stale bits above fill vanish).
  always_comb begin
    shifted  = buf_i >> (32'(shift_frames_i) * FRAME);
    ins_data = BUF_W'(ins_data_i) << (32'(ins_frame_i) * FRAME);
    ins_mask = BUF_W'({INS_W{1'b1}}) << (32'(ins_frame_i) * FRAME);
    buf_o    = ins_en_i ? ((shifted & ~ins_mask) | (ins_data & ins_mask)) : shifted;
  end

endmodule

// File: rtl/rr_trace_split.sv
// Replay trace splitter: re-splits densely packed DRAM beats into the original
// length-prefixed, frame-aligned record packets, one packet per output write.
// Build option RR_SPLIT_ZERO_FILL_EN: when defined, output bits at or above the
// packet width are forced to zero; otherwise they carry stale buffer bits.
module rr_trace_split
  import rr_trace_pkg::*;
#(
  parameter int unsigned WIDTH        = 2560,
  parameter int unsigned AXI_WIDTH    = 512,
  parameter int unsigned OFFSET_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    replay_start,
  input  logic [OFFSET_WIDTH-1:0] replay_trace_size,
  input  logic [AXI_WIDTH-1:0]    replay_in_fifo_out,
  input  logic                    replay_in_fifo_empty,
  output logic                    replay_in_fifo_rd_en,
  output logic [WIDTH-1:0]        replay_out_fifo_in,
  output logic [OFFSET_WIDTH-1:0] replay_out_fifo_in_width,
  output logic                    replay_out_fifo_wr_en,
  input  logic                    replay_out_fifo_almfull,
  output logic                    replay_done,
  output logic                    replay_error
);

  localparam int unsigned BUF_W  = WIDTH + AXI_WIDTH;
  localparam int unsigned NF     = BUF_W / PACKET_ALIGNMENT;
  localparam int unsigned FW     = $clog2(NF + 1);
  localparam int unsigned OUT_NF = WIDTH / PACKET_ALIGNMENT;

  localparam logic [OFFSET_WIDTH-1:0] AxiW   = OFFSET_WIDTH'(AXI_WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] BufW   = OFFSET_WIDTH'(BUF_W);
  localparam logic [OFFSET_WIDTH-1:0] MaxW   = OFFSET_WIDTH'(WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] AlignW = OFFSET_WIDTH'(PACKET_ALIGNMENT);

  rr_split_state_t         state_q, state_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [OFFSET_WIDTH-1:0] fill_q, fill_d;
  logic [OFFSET_WIDTH-1:0] consumed_q, consumed_d;
  logic [OFFSET_WIDTH-1:0] loaded_q, loaded_d;
  logic [OFFSET_WIDTH-1:0] size_q, size_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic [OFFSET_WIDTH-1:0] width_q, width_d;
  logic                    wr_en_q, wr_en_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [OFFSET_WIDTH-1:0] hdr_len, remaining, to_load, beat_bits, beat_raw, fill_after;
  logic                    hdr_seen, hdr_bad, running, emit, pop;
  logic [FW-1:0]           shift_frames, ins_frame;
  logic [BUF_W-1:0]        buf_next;
  logic [WIDTH-1:0]        out_data;

  // Header decode, emit/pop decisions and beat accounting for this cycle.
  always_comb begin
    hdr_len   = OFFSET_WIDTH'(buf_q[LEN_BITS-1:0]);
    hdr_seen  = fill_q >= AlignW;
    remaining = size_q - consumed_q;
    hdr_bad   = hdr_seen && ((hdr_len == '0) || (hdr_len > MaxW) ||
                             ((hdr_len % AlignW) != '0) || (hdr_len > remaining));
    running   = (state_q == StRun) && (consumed_q != size_q);
    emit      = running && hdr_seen && !hdr_bad && (fill_q >= hdr_len) &&
                !replay_out_fifo_almfull;
    fill_after = emit ? (fill_q - hdr_len) : fill_q;
    to_load   = size_q - loaded_q;
    // Padding above the trace end in the final beat never counts toward fill.
    beat_raw  = (to_load > AxiW) ? AxiW : to_load;
    beat_bits = OFFSET_WIDTH'(get_force_aligned_frame(32'(beat_raw)));
    pop       = running && !hdr_bad && !replay_in_fifo_empty && (loaded_q != size_q) &&
                ((fill_after + AxiW) <= BufW);
    shift_frames = emit ? FW'(hdr_len / AlignW) : '0;
    ins_frame    = FW'(fill_after / AlignW);
  end

  assign replay_in_fifo_rd_en = pop;

  rr_aligned_shifter #(
    .BUF_W (BUF_W),
    .INS_W (AXI_WIDTH),
    .FRAME (PACKET_ALIGNMENT)
  ) u_shifter (
    .buf_i          (buf_q),
    .shift_frames_i (shift_frames),
    .ins_en_i       (pop),
    .ins_frame_i    (ins_frame),
    .ins_data_i     (replay_in_fifo_out),
    .buf_o          (buf_next)
  );

  // Packet data presented to the output register, optionally masked to its width.
  always_comb begin
    out_data = buf_q[WIDTH-1:0];
`ifdef RR_SPLIT_ZERO_FILL_EN
    for (int unsigned f = 0; f < OUT_NF; f++) begin
      if (OFFSET_WIDTH'(f * PACKET_ALIGNMENT) >= hdr_len) begin
        out_data[f*PACKET_ALIGNMENT +: PACKET_ALIGNMENT] = '0;
      end
    end
`endif
  end

  // FSM next state plus buffer, counters and registered output strobes.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    consumed_d = consumed_q;
    loaded_d   = loaded_q;
    size_d     = size_q;
    out_d      = out_q;
    width_d    = width_q;
    wr_en_d    = 1'b0;
    done_d     = done_q;
    error_d    = error_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (replay_start) begin
          size_d     = replay_trace_size;
          fill_d     = '0;
          consumed_d = '0;
          loaded_d   = '0;
          error_d    = 1'b0;
          done_d     = (replay_trace_size == '0);
          state_d    = (replay_trace_size == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (consumed_q == size_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (hdr_bad) begin
          state_d = StError;
          error_d = 1'b1;
        end else begin
          buf_d    = buf_next;
          fill_d   = fill_after + (pop ? beat_bits : '0);
          loaded_d = loaded_q + (pop ? beat_raw : '0);
          if (emit) begin
            wr_en_d    = 1'b1;
            out_d      = out_data;
            width_d    = hdr_len;
            consumed_d = consumed_q + hdr_len;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset discards any partial buffer contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      fill_q     <= '0;
      consumed_q <= '0;
      loaded_q   <= '0;
      size_q     <= '0;
      out_q      <= '0;
      width_q    <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      consumed_q <= consumed_d;
      loaded_q   <= loaded_d;
      size_q     <= size_d;
      out_q      <= out_d;
      width_q    <= width_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign replay_out_fifo_in       = out_q;
  assign replay_out_fifo_in_width = width_q;
  assign replay_out_fifo_wr_en    = wr_en_q;
  assign replay_done              = done_q;
  assign replay_error             = error_q;

endmodule

// File: tb/tb_rr_trace_split.sv
// Directed bench for rr_trace_split: builds traces from packets, feeds them
// through an FWFT FIFO model and scoreboards the split packets.
module tb_rr_trace_split;

  localparam int unsigned WIDTH     = 2560;
  localparam int unsigned AXI_WIDTH = 512;
  localparam int unsigned OW        = 32;
  localparam int unsigned FPB       = AXI_WIDTH / 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 replay_start;
  logic [OW-1:0]        replay_trace_size;
  logic [AXI_WIDTH-1:0] replay_in_fifo_out;
  logic                 replay_in_fifo_empty;
  logic                 replay_in_fifo_rd_en;
  logic [WIDTH-1:0]     replay_out_fifo_in;
  logic [OW-1:0]        replay_out_fifo_in_width;
  logic                 replay_out_fifo_wr_en;
  logic                 replay_out_fifo_almfull;
  logic                 replay_done;
  logic                 replay_error;

  rr_trace_split #(
    .WIDTH        (WIDTH),
    .AXI_WIDTH    (AXI_WIDTH),
    .OFFSET_WIDTH (OW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .replay_start             (replay_start),
    .replay_trace_size        (replay_trace_size),
    .replay_in_fifo_out       (replay_in_fifo_out),
    .replay_in_fifo_empty     (replay_in_fifo_empty),
    .replay_in_fifo_rd_en     (replay_in_fifo_rd_en),
    .replay_out_fifo_in       (replay_out_fifo_in),
    .replay_out_fifo_in_width (replay_out_fifo_in_width),
    .replay_out_fifo_wr_en    (replay_out_fifo_wr_en),
    .replay_out_fifo_almfull  (replay_out_fifo_almfull),
    .replay_done              (replay_done),
    .replay_error             (replay_error)
  );

  always #5 clk = ~clk;

  logic [AXI_WIDTH-1:0] beats_q[$];
  logic [31:0]          frames_q[$];
  int unsigned          exp_w[$];
  logic [WIDTH-1:0]     exp_d[$];
  int unsigned          got_w[$];
  logic [WIDTH-1:0]     got_d[$];
  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   pops     = 0;
  int                   af_viol  = 0;
  logic                 af_seen  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FWFT read side: pop on rd_en, remember almfull as seen by the DUT at this edge.
  always @(posedge clk) begin
    if (replay_in_fifo_rd_en) begin
      pops++;
      if (beats_q.size() > 0) void'(beats_q.pop_front());
    end
    af_seen = replay_out_fifo_almfull;
  end

  // Capture writes away from the active edge and refresh the FIFO head.
  always @(negedge clk) begin
    if (replay_out_fifo_wr_en) begin
      got_w.push_back(replay_out_fifo_in_width);
      got_d.push_back(replay_out_fifo_in);
      if (af_seen) af_viol++;
    end
    replay_in_fifo_empty = (beats_q.size() == 0);
    replay_in_fifo_out   = replay_in_fifo_empty ? '0 : beats_q[0];
  end

  // Order-sensitive digest of the packet bits that must match.
  function automatic logic [63:0] fold(input logic [WIDTH-1:0] d, input int unsigned w);
    logic [63:0] h;
    h = '0;
`ifndef RR_SPLIT_ZERO_FILL_EN
    if (w < WIDTH) d = d & ~({WIDTH{1'b1}} << w);
`endif
    for (int c = 0; c < WIDTH / 64; c++) h = {h[62:0], h[63]} ^ d[c*64 +: 64];
    return h;
  endfunction

  // Append a packet of len bits whose header says hdr; keep marks it as expected output.
  task automatic add_pkt(input int unsigned len, input int unsigned hdr, input bit keep);
    logic [WIDTH-1:0] d;
    logic [31:0]      w;
    d = '0;
    for (int f = 0; f < int'(len / 32); f++) begin
      w = $urandom();
      if (f == 0) w[15:0] = hdr[15:0];
      frames_q.push_back(w);
      d[f*32 +: 32] = w;
    end
    if (keep) begin
      exp_w.push_back(len);
      exp_d.push_back(d);
    end
  endtask

  // Pack pending frames into beats, padding the last one.
  task automatic build(input logic [31:0] pad, output int unsigned bits);
    logic [AXI_WIDTH-1:0] b;
    bits = 32 * frames_q.size();
    while (frames_q.size() > 0) begin
      for (int f = 0; f < int'(FPB); f++) begin
        if (frames_q.size() > 0) b[f*32 +: 32] = frames_q.pop_front();
        else                     b[f*32 +: 32] = pad;
      end
      beats_q.push_back(b);
    end
  endtask

  task automatic start_trace(input int unsigned size);
    got_w.delete();
    got_d.delete();
    pops    = 0;
    af_viol = 0;
    @(negedge clk);
    replay_trace_size = size;
    replay_start      = 1'b1;
    @(negedge clk);
    replay_start      = 1'b0;
  endtask

  // mode 0: no back-pressure, 1: almfull toggles every 3 cycles, 2: random almfull.
  task automatic wait_end(input string tag, input int budget, input int mode);
    int i;
    i = 0;
    while (!(replay_done || replay_error) && i < budget) begin
      @(negedge clk);
      if (mode == 1) replay_out_fifo_almfull = ((i / 3) % 2) == 1;
      if (mode == 2) replay_out_fifo_almfull = ($urandom_range(0, 3) == 0);
      i++;
    end
    replay_out_fifo_almfull = 1'b0;
    check_eq({tag, " finished in time"}, 64'(i < budget), 64'd1);
  endtask

  task automatic compare_pkts(input string tag);
    check_eq({tag, " write count"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      check_eq($sformatf("%s pkt%0d width", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
      check_eq($sformatf("%s pkt%0d data", tag, i), fold(got_d[i], exp_w[i]),
               fold(exp_d[i], exp_w[i]));
    end
    exp_w.delete();
    exp_d.delete();
  endtask

  initial begin
    int unsigned bits;
    int          pops_at, writes_at;
    rst = 1'b1;
    replay_start = 1'b0;
    replay_trace_size = '0;
    replay_out_fifo_almfull = 1'b0;
    replay_in_fifo_empty = 1'b1;
    replay_in_fifo_out = '0;
    repeat (3) @(negedge clk);
    check_eq("reset wr_en", 64'(replay_out_fifo_wr_en), 64'd0);
    check_eq("reset done", 64'(replay_done), 64'd0);
    check_eq("reset error", 64'(replay_error), 64'd0);
    check_eq("reset rd_en", 64'(replay_in_fifo_rd_en), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-size trace completes immediately with no writes.
    start_trace(0);
    check_eq("size0 done", 64'(replay_done), 64'd1);
    check_eq("size0 writes", 64'(got_w.size()), 64'd0);

    // 64 + 448 in one beat.
    add_pkt(64, 64, 1);
    add_pkt(448, 448, 1);
    build(32'h0, bits);
    start_trace(bits);
    wait_end("t1", 200, 0);
    compare_pkts("t1");
    check_eq("t1 done", 64'(replay_done), 64'd1);
    check_eq("t1 error", 64'(replay_error), 64'd0);

    // One maximum-width packet over five beats under toggling back-pressure.
    add_pkt(2560, 2560, 1);
    build(32'h0, bits);
    start_trace(bits);
    wait_end("t2", 400, 1);
    compare_pkts("t2");
    check_eq("t2 no wr_en after almfull", 64'(af_viol), 64'd0);
    check_eq("t2 beats popped", 64'(pops), 64'd5);

    // Three 96-bit packets, last beat padded with ones.
    for (int k = 0; k < 3; k++) add_pkt(96, 96, 1);
    build(32'hFFFF_FFFF, bits);
    check_eq("t3 trace bits", 64'(bits), 64'd288);
    start_trace(bits);
    wait_end("t3", 200, 0);
    compare_pkts("t3");
    check_eq("t3 done", 64'(replay_done), 64'd1);

    // Unaligned header in the second packet stops everything.
    add_pkt(64, 64, 1);
    add_pkt(64, 48, 0);
    add_pkt(896, 896, 0);
    build(32'h0, bits);
    start_trace(bits);
    wait_end("t4", 200, 0);
    compare_pkts("t4");
    check_eq("t4 error", 64'(replay_error), 64'd1);
    check_eq("t4 done", 64'(replay_done), 64'd0);
    pops_at   = pops;
    writes_at = got_w.size();
    repeat (20) @(negedge clk);
    check_eq("t4 no rd_en after error", 64'(pops), 64'(pops_at));
    check_eq("t4 no wr_en after error", 64'(got_w.size()), 64'(writes_at));
    beats_q.delete();

    // Reset mid-packet, then a fresh trace.
    add_pkt(2560, 2560, 0);
    build(32'h0, bits);
    while (beats_q.size() > 2) void'(beats_q.pop_back());
    start_trace(bits);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    beats_q.delete();
    @(negedge clk);
    check_eq("t5 reset error", 64'(replay_error), 64'd0);
    check_eq("t5 reset wr_en", 64'(replay_out_fifo_wr_en), 64'd0);
    check_eq("t5 writes before reset", 64'(got_w.size()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    add_pkt(128, 128, 1);
    add_pkt(384, 384, 1);
    build(32'h0, bits);
    start_trace(bits);
    wait_end("t5", 200, 0);
    compare_pkts("t5");
    check_eq("t5 done", 64'(replay_done), 64'd1);

    // Loopback of random-width packets with random back-pressure.
    for (int k = 0; k < 1000; k++) begin
      bits = 32 * $urandom_range(1, 80);
      add_pkt(bits, bits, 1);
    end
    build($urandom(), bits);
    start_trace(bits);
    wait_end("t6", 40000, 2);
    compare_pkts("t6");
    check_eq("t6 no wr_en after almfull", 64'(af_viol), 64'd0);
    check_eq("t6 done", 64'(replay_done), 64'd1);
    check_eq("t6 error", 64'(replay_error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
